fft_pingpong_buffer: RTL

- Parametrised, double-banked (ping-pong) sample store for the FFT accelerator.
- Replaces the single flat FFT memory with two banks:
  - the host side loads and unloads one bank through a valid/ready request/response port;
  - the FFT engine reads and writes the other bank through a fixed-latency port.
- A swap handshake exchanges bank ownership only once both sides are quiescent.
- Out-of-length host accesses are rejected and flagged, based on the current FFT length.

---
 rtl/fft_pingpong_buffer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fft_pingpong_buffer.sv
// Double-banked FFT sample store: the host loads/unloads one bank while the engine works on the other.
// Bank ownership is exchanged through a RUN/DRAIN handshake once both sides are quiescent.
module fft_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [LEN_WIDTH-1:0]  length_log2_i,
    input  logic                  host_req_valid_i,
    output logic                  host_req_ready_o,
    input  logic                  host_req_write_i,
    input  logic [ADDR_WIDTH-1:0] host_req_addr_i,
    input  logic [DATA_WIDTH-1:0] host_req_wdata_i,
    output logic                  host_rsp_valid_o,
    input  logic                  host_rsp_ready_i,
    output logic [DATA_WIDTH-1:0] host_rsp_rdata_o,
    output logic                  host_rsp_err_o,
    input  logic                  eng_en_i,
    input  logic                  eng_we_i,
    input  logic [ADDR_WIDTH-1:0] eng_addr_i,
    input  logic [DATA_WIDTH-1:0] eng_wdata_i,
    output logic [DATA_WIDTH-1:0] eng_rdata_o,
    input  logic                  eng_busy_i,
    input  logic                  swap_req_i,
    output logic                  swap_done_o,
    output logic                  host_bank_o,
    output logic [7:0]            swap_count_o,
    output logic [7:0]            err_count_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(ADDR_WIDTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t state_q, state_d;
    logic   swap_fire;

    logic [DATA_WIDTH-1:0] bank0_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] bank1_mem [0:DEPTH-1];

    logic [LEN_WIDTH-1:0]  len_eff;
    logic                  addr_in_range;
    logic                  host_accept;
    logic                  host_wr;
    logic                  eng_wr;
    logic [DATA_WIDTH-1:0] host_mem_rdata;
    logic [DATA_WIDTH-1:0] eng_mem_rdata;

    // An address is legal when all bits at or above the active length are zero.
    assign len_eff       = (length_log2_i > LEN_MAX) ? LEN_MAX : length_log2_i;
    assign addr_in_range = ((host_req_addr_i >> len_eff) == '0);

    assign host_req_ready_o = reset_n_i & (state_q == RUN) & (~host_rsp_valid_o | host_rsp_ready_i);
    assign host_accept      = host_req_valid_i & host_req_ready_o;
    assign host_wr          = host_accept & host_req_write_i & addr_in_range;
    assign eng_wr           = eng_en_i & eng_we_i;

    assign host_mem_rdata = host_bank_o ? bank1_mem[host_req_addr_i] : bank0_mem[host_req_addr_i];
    assign eng_mem_rdata  = host_bank_o ? bank0_mem[eng_addr_i]      : bank1_mem[eng_addr_i];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        swap_fire = 1'b0;
        case (state_q)
            RUN: begin
                if (swap_req_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (~eng_busy_i & (~host_rsp_valid_o | host_rsp_ready_i)) begin
                    state_d   = RUN;
                    swap_fire = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // The ports always target opposite banks, so each bank sees at most one writer.
    always_ff @(posedge clk_i) begin
        if (host_bank_o ? eng_wr : host_wr) begin
            bank0_mem[host_bank_o ? eng_addr_i : host_req_addr_i] <=
                host_bank_o ? eng_wdata_i : host_req_wdata_i;
        end
        if (host_bank_o ? host_wr : eng_wr) begin
            bank1_mem[host_bank_o ? host_req_addr_i : eng_addr_i] <=
                host_bank_o ? host_req_wdata_i : eng_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            host_rsp_valid_o <= 1'b0;
            host_rsp_rdata_o <= '0;
            host_rsp_err_o   <= 1'b0;
            err_count_o      <= 8'd0;
        end else begin
            if (host_accept & ~host_req_write_i) begin
                host_rsp_valid_o <= 1'b1;
                host_rsp_rdata_o <= addr_in_range ? host_mem_rdata : '0;
                host_rsp_err_o   <= ~addr_in_range;
            end else if (host_rsp_ready_i) begin
                host_rsp_valid_o <= 1'b0;
            end
            if (host_accept & ~addr_in_range & (err_count_o != 8'hFF)) begin
                err_count_o <= err_count_o + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            eng_rdata_o <= '0;
        end else if (eng_en_i & ~eng_we_i) begin
            eng_rdata_o <= eng_mem_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            host_bank_o  <= 1'b0;
            swap_done_o  <= 1'b0;
            swap_count_o <= 8'd0;
        end else begin
            swap_done_o <= swap_fire;
            if (swap_fire) begin
                host_bank_o  <= ~host_bank_o;
                swap_count_o <= swap_count_o + 8'd1;
            end
        end
    end

endmodule
